// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1280x1024@60 raster timing generator with a one-stage
// registered colour/sync output. The optional frame counter output is built
// only when VGA_FRAME_CNT_EN is defined.
//
// state      | meaning (applies to both the horizontal and vertical phase FSMs)
// PH_ACTIVE  | visible pixels / lines
// PH_FRONT   | front porch
// PH_SYNC    | sync pulse asserted
// PH_BACK    | back porch, ends at the counter wrap
`timescale 1ns/1ps
module vga_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 48,
    parameter int H_SYNC   = 112,
    parameter int H_BP     = 248,
    parameter int V_ACTIVE = 1024,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 38,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk_108,
    input  logic        rst,
    input  logic        ce,
    input  logic [3:0]  pix_red,
    input  logic [3:0]  pix_green,
    input  logic [3:0]  pix_blue,
    output logic [11:0] VGA_HORZ_COORD,
    output logic [11:0] VGA_VERT_COORD,
    output logic        VGA_ACTIVE,
    output logic        VGA_FRAME_START,
    output logic [3:0]  VGA_RED,
    output logic [3:0]  VGA_GREEN,
    output logic [3:0]  VGA_BLUE,
    output logic        VGA_HS,
    output logic        VGA_VS
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] VGA_FRAME_CNT
`endif
);

    localparam logic [11:0] H_ACT_N   = 12'(H_ACTIVE);
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_FP_END  = 12'(H_ACTIVE + H_FP - 1);
    localparam logic [11:0] H_SY_END  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_ACT_N   = 12'(V_ACTIVE);
    localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE - 1);
    localparam logic [11:0] V_FP_END  = 12'(V_ACTIVE + V_FP - 1);
    localparam logic [11:0] V_SY_END  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST    = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic        SYNC_IDLE = ~SYNC_POL;

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    logic [11:0] r_h;
    logic [11:0] r_v;
    phase_t      r_hstate;
    phase_t      r_vstate;
    phase_t      w_hstate_nxt;
    phase_t      w_vstate_nxt;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    logic        w_hs_raw;
    logic        w_vs_raw;
    logic [3:0]  r_red;
    logic [3:0]  r_green;
    logic [3:0]  r_blue;
    logic        r_hs;
    logic        r_vs;

    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_active = (r_h < H_ACT_N) && (r_v < V_ACT_N);
    assign w_hs_raw = (r_hstate == PH_SYNC) ? SYNC_POL : SYNC_IDLE;
    assign w_vs_raw = (r_vstate == PH_SYNC) ? SYNC_POL : SYNC_IDLE;

    // Pixel and line counters; the line counter steps on the pixel wrap.
    always_ff @(posedge clk_108) begin
        if (rst) begin
            r_h <= 12'd0;
            r_v <= 12'd0;
        end else if (ce) begin
            r_h <= w_h_last ? 12'd0 : r_h + 12'd1;
            if (w_h_last) begin
                r_v <= w_v_last ? 12'd0 : r_v + 12'd1;
            end
        end
    end

    // Phase state registers for both axes.
    always_ff @(posedge clk_108) begin
        if (rst) begin
            r_hstate <= PH_ACTIVE;
            r_vstate <= PH_ACTIVE;
        end else begin
            r_hstate <= w_hstate_nxt;
            r_vstate <= w_vstate_nxt;
        end
    end

    // Phase next-state: moves on the same edge the counter leaves a region.
    always_comb begin
        w_hstate_nxt = r_hstate;
        w_vstate_nxt = r_vstate;
        if (ce) begin
            case (r_hstate)
                PH_ACTIVE: if (r_h == H_ACT_END) w_hstate_nxt = PH_FRONT;
                PH_FRONT:  if (r_h == H_FP_END)  w_hstate_nxt = PH_SYNC;
                PH_SYNC:   if (r_h == H_SY_END)  w_hstate_nxt = PH_BACK;
                PH_BACK:   if (w_h_last)         w_hstate_nxt = PH_ACTIVE;
                default:                         w_hstate_nxt = PH_ACTIVE;
            endcase
            if (w_h_last) begin
                case (r_vstate)
                    PH_ACTIVE: if (r_v == V_ACT_END) w_vstate_nxt = PH_FRONT;
                    PH_FRONT:  if (r_v == V_FP_END)  w_vstate_nxt = PH_SYNC;
                    PH_SYNC:   if (r_v == V_SY_END)  w_vstate_nxt = PH_BACK;
                    PH_BACK:   if (w_v_last)         w_vstate_nxt = PH_ACTIVE;
                    default:                         w_vstate_nxt = PH_ACTIVE;
                endcase
            end
        end
    end

    // Output stage: blank outside the active area, keep sync aligned to colour.
    always_ff @(posedge clk_108) begin
        if (rst) begin
            r_red   <= 4'd0;
            r_green <= 4'd0;
            r_blue  <= 4'd0;
            r_hs    <= SYNC_IDLE;
            r_vs    <= SYNC_IDLE;
        end else if (ce) begin
            r_red   <= w_active ? pix_red   : 4'd0;
            r_green <= w_active ? pix_green : 4'd0;
            r_blue  <= w_active ? pix_blue  : 4'd0;
            r_hs    <= w_hs_raw;
            r_vs    <= w_vs_raw;
        end
    end

    assign VGA_HORZ_COORD  = r_h;
    assign VGA_VERT_COORD  = r_v;
    assign VGA_ACTIVE      = w_active;
    assign VGA_FRAME_START = (r_h == 12'd0) && (r_v == 12'd0) && ce;
    assign VGA_RED         = r_red;
    assign VGA_GREEN       = r_green;
    assign VGA_BLUE        = r_blue;
    assign VGA_HS          = r_hs;
    assign VGA_VS          = r_vs;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Frame counter for drawer animation; wraps naturally at 16 bits.
    always_ff @(posedge clk_108) begin
        if (rst) begin
            r_frame_cnt <= 16'd0;
        end else if (VGA_FRAME_START) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign VGA_FRAME_CNT = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for horizontal timing, and a
// reduced-geometry instance (16x9 total) for frame-level behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;
    logic [3:0] pr = 4'hA;
    logic [3:0] pg = 4'h5;
    logic [3:0] pb = 4'h3;

    logic [11:0] d_h, d_v, s_h, s_v;
    logic        d_act, d_fs, d_hs, d_vs, s_act, s_fs, s_hs, s_vs;
    logic [3:0]  d_red, d_grn, d_blu, s_red, s_grn, s_blu;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vga_timing_gen d (
        .clk_108(clk), .rst(rst), .ce(ce),
        .pix_red(pr), .pix_green(pg), .pix_blue(pb),
        .VGA_HORZ_COORD(d_h), .VGA_VERT_COORD(d_v),
        .VGA_ACTIVE(d_act), .VGA_FRAME_START(d_fs),
        .VGA_RED(d_red), .VGA_GREEN(d_grn), .VGA_BLUE(d_blu),
        .VGA_HS(d_hs), .VGA_VS(d_vs)
`ifdef VGA_FRAME_CNT_EN
        , .VGA_FRAME_CNT(d_fc)
`endif
    );

    // Small geometry: H 8/2/3/3 (total 16), V 4/1/2/2 (total 9), frame 144 clocks.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) s (
        .clk_108(clk), .rst(rst), .ce(ce),
        .pix_red(pr), .pix_green(pg), .pix_blue(pb),
        .VGA_HORZ_COORD(s_h), .VGA_VERT_COORD(s_v),
        .VGA_ACTIVE(s_act), .VGA_FRAME_START(s_fs),
        .VGA_RED(s_red), .VGA_GREEN(s_grn), .VGA_BLUE(s_blu),
        .VGA_HS(s_hs), .VGA_VS(s_vs)
`ifdef VGA_FRAME_CNT_EN
        , .VGA_FRAME_CNT(s_fc)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        tick(); tick();
        checks++; if (d_h !== 12'd0) begin errors++; $display("FAIL reset_h got=%0d exp=0", d_h); end
        checks++; if (d_v !== 12'd0) begin errors++; $display("FAIL reset_v got=%0d exp=0", d_v); end
        checks++; if (d_act !== 1'b1) begin errors++; $display("FAIL reset_active got=%b exp=1", d_act); end
        checks++; if (d_fs !== 1'b1) begin errors++; $display("FAIL reset_frame_start got=%b exp=1", d_fs); end
        checks++; if ({d_red, d_grn, d_blu} !== 12'h000) begin errors++; $display("FAIL reset_rgb got=%h exp=000", {d_red, d_grn, d_blu}); end
        checks++; if ({d_hs, d_vs} !== 2'b00) begin errors++; $display("FAIL reset_sync got=%b exp=00", {d_hs, d_vs}); end
        checks++; if ({s_h, s_v} !== 24'd0) begin errors++; $display("FAIL reset_small_coord got=%h exp=0", {s_h, s_v}); end
    endtask

    // One full line on the full-size instance; colour/sync lag coordinates by one clock.
    task automatic test_h_sweep();
        int hs_cnt;
        int ph, eh, ev;
        logic [3:0] er;
        logic ehs, eact;
        hs_cnt = 0;
        rst = 1'b0; ce = 1'b1;
        for (int k = 1; k <= 1688; k++) begin
            tick();
            ph   = k - 1;
            eh   = k % 1688;
            ev   = (k == 1688) ? 1 : 0;
            er   = (ph < 1280) ? 4'hA : 4'h0;
            ehs  = (ph >= 1328) && (ph <= 1439);
            eact = (eh < 1280);
            if (d_hs === 1'b1) hs_cnt++;
            checks++; if (d_h !== 12'(eh)) begin errors++; $display("FAIL sweep_h k=%0d got=%0d exp=%0d", k, d_h, eh); end
            checks++; if (d_v !== 12'(ev)) begin errors++; $display("FAIL sweep_v k=%0d got=%0d exp=%0d", k, d_v, ev); end
            checks++; if (d_red !== er) begin errors++; $display("FAIL sweep_red k=%0d got=%h exp=%h", k, d_red, er); end
            checks++; if (d_hs !== ehs) begin errors++; $display("FAIL sweep_hs k=%0d got=%b exp=%b", k, d_hs, ehs); end
            checks++; if (d_act !== eact) begin errors++; $display("FAIL sweep_active k=%0d got=%b exp=%b", k, d_act, eact); end
            checks++; if (d_vs !== 1'b0) begin errors++; $display("FAIL sweep_vs k=%0d got=%b exp=0", k, d_vs); end
        end
        checks++; if (hs_cnt != 112) begin errors++; $display("FAIL sweep_hs_width got=%0d exp=112", hs_cnt); end
        checks++; if (d_fs !== 1'b0) begin errors++; $display("FAIL sweep_no_fs_line1 got=%b exp=0", d_fs); end
        checks++; if ({d_grn, d_blu} !== 8'h00) begin errors++; $display("FAIL sweep_gb_blank got=%h exp=00", {d_grn, d_blu}); end
    endtask

    // One full frame on the small instance.
    task automatic test_frame();
        int fs_cnt, vs_cnt, hs_cnt;
        int ph, pv, eh, ev;
        logic [3:0] er;
        logic ehs, evs;
        fs_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        do_reset();
        for (int n = 0; n < 144; n++) begin
            if (s_fs === 1'b1) fs_cnt++;
            tick();
            ph  = n % 16;
            pv  = n / 16;
            eh  = (n + 1) % 16;
            ev  = ((n + 1) / 16) % 9;
            er  = (ph < 8 && pv < 4) ? 4'hA : 4'h0;
            ehs = (ph >= 10) && (ph <= 12);
            evs = (pv >= 5) && (pv <= 6);
            if (s_vs === 1'b1) vs_cnt++;
            if (s_hs === 1'b1) hs_cnt++;
            checks++; if ({s_h, s_v} !== {12'(eh), 12'(ev)}) begin errors++; $display("FAIL frame_coord n=%0d got=%0d,%0d exp=%0d,%0d", n, s_h, s_v, eh, ev); end
            checks++; if (s_red !== er) begin errors++; $display("FAIL frame_red n=%0d got=%h exp=%h", n, s_red, er); end
            checks++; if (s_hs !== ehs) begin errors++; $display("FAIL frame_hs n=%0d got=%b exp=%b", n, s_hs, ehs); end
            checks++; if (s_vs !== evs) begin errors++; $display("FAIL frame_vs n=%0d got=%b exp=%b", n, s_vs, evs); end
        end
        checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_fs_count got=%0d exp=1", fs_cnt); end
        checks++; if (vs_cnt != 32) begin errors++; $display("FAIL frame_vs_width got=%0d exp=32", vs_cnt); end
        checks++; if (hs_cnt != 27) begin errors++; $display("FAIL frame_hs_total got=%0d exp=27", hs_cnt); end
        checks++; if (s_fs !== 1'b1) begin errors++; $display("FAIL frame_wrap_fs got=%b exp=1", s_fs); end
    endtask

    // Alternate ce: state holds on disabled clocks, frame period doubles.
    task automatic test_ce_toggle();
        int pulses[$];
        logic [11:0] p_sh, p_dh;
        logic [3:0]  p_sred;
        logic        p_shs, was_en;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            ce = (k % 2 == 0);
            was_en = ce;
            #1;
            if (s_fs === 1'b1) pulses.push_back(k);
            if (!was_en && s_h == 12'd0 && s_v == 12'd0) begin
                checks++; if (s_fs !== 1'b0) begin errors++; $display("FAIL ce_fs_suppressed k=%0d got=%b exp=0", k, s_fs); end
            end
            p_sh = s_h; p_dh = d_h; p_sred = s_red; p_shs = s_hs;
            tick();
            if (!was_en) begin
                checks++; if ({s_h, d_h} !== {p_sh, p_dh}) begin errors++; $display("FAIL ce_hold_h k=%0d got=%0d,%0d exp=%0d,%0d", k, s_h, d_h, p_sh, p_dh); end
                checks++; if ({s_red, s_hs} !== {p_sred, p_shs}) begin errors++; $display("FAIL ce_hold_out k=%0d got=%h,%b exp=%h,%b", k, s_red, s_hs, p_sred, p_shs); end
            end else begin
                checks++; if (s_h !== ((p_sh + 12'd1) % 12'd16)) begin errors++; $display("FAIL ce_advance k=%0d got=%0d exp=%0d", k, s_h, (p_sh + 12'd1) % 12'd16); end
            end
        end
        ce = 1'b1;
        checks++; if (pulses.size() != 3) begin errors++; $display("FAIL ce_pulse_count got=%0d exp=3", pulses.size()); end
        if (pulses.size() >= 2) begin
            checks++; if (pulses[1] - pulses[0] != 288) begin errors++; $display("FAIL ce_frame_period got=%0d exp=288", pulses[1] - pulses[0]); end
        end
    endtask

    // Reset mid-frame (small instance inside vsync, full instance mid-line) with ce low.
    task automatic test_mid_reset();
        do_reset();
        for (int n = 0; n < 90; n++) tick();
        checks++; if ({s_h, s_v} !== {12'd10, 12'd5}) begin errors++; $display("FAIL mid_pre_coord got=%0d,%0d exp=10,5", s_h, s_v); end
        checks++; if (s_vs !== 1'b1) begin errors++; $display("FAIL mid_pre_vs got=%b exp=1", s_vs); end
        checks++; if (d_red !== 4'hA) begin errors++; $display("FAIL mid_pre_red got=%h exp=a", d_red); end
        rst = 1'b1; ce = 1'b0;
        tick();
        checks++; if ({d_h, d_v, s_h, s_v} !== 48'd0) begin errors++; $display("FAIL mid_rst_coord got=%0d,%0d,%0d,%0d exp=0,0,0,0", d_h, d_v, s_h, s_v); end
        checks++; if ({d_red, d_grn, d_blu} !== 12'h000) begin errors++; $display("FAIL mid_rst_rgb got=%h exp=000", {d_red, d_grn, d_blu}); end
        checks++; if ({s_hs, s_vs, d_hs, d_vs} !== 4'b0000) begin errors++; $display("FAIL mid_rst_sync got=%b exp=0000", {s_hs, s_vs, d_hs, d_vs}); end
        rst = 1'b0; ce = 1'b1;
        tick();
        checks++; if ({d_h, d_red} !== {12'd1, 4'hA}) begin errors++; $display("FAIL mid_resume_first got=%0d,%h exp=1,a", d_h, d_red); end
        for (int n = 1; n < 16; n++) tick();
        checks++; if ({s_h, s_v} !== {12'd0, 12'd1}) begin errors++; $display("FAIL mid_resume_wrap got=%0d,%0d exp=0,1", s_h, s_v); end
        checks++; if (d_h !== 12'd16) begin errors++; $display("FAIL mid_resume_h got=%0d exp=16", d_h); end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        do_reset();
        checks++; if (s_fc !== 16'd0) begin errors++; $display("FAIL fc_reset got=%0d exp=0", s_fc); end
        for (int n = 0; n < 432; n++) tick();
        checks++; if (s_fc !== 16'd3) begin errors++; $display("FAIL fc_three_frames got=%0d exp=3", s_fc); end
        checks++; if (d_fc !== 16'd1) begin errors++; $display("FAIL fc_full_size got=%0d exp=1", d_fc); end
        force s.r_frame_cnt = 16'hFFFF;
        #1;
        release s.r_frame_cnt;
        tick();
        checks++; if (s_fc !== 16'd0) begin errors++; $display("FAIL fc_wrap got=%0d exp=0", s_fc); end
    endtask
`endif

    initial begin
        test_reset();
        test_h_sweep();
        test_frame();
        test_ce_toggle();
        test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 1280x1024@60 VGA raster timing: horizontal/vertical pixel counters, sync pulses and active-video flag. Drives VGA_HORZ_COORD/VGA_VERT_COORD into the background, wave and overlay drawers. Takes their combinational 4-bit RGB back and registers it, blanking pixels outside the active area. Sync outputs are delayed by the same pipeline stage so they stay aligned with the colour outputs. Sits between the pixel-clock domain and the VGA connector.

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 48, horizontal front porch (pixels)
H_SYNC, 112, hsync width (pixels)
H_BP, 248, horizontal back porch (pixels); line total = 1688
V_ACTIVE, 1024, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 38, vertical back porch (lines); frame total = 1066
SYNC_POL, 1, asserted level of hsync/vsync (1 = positive)

Ports:
clk_108  in  1  pixel clock, 108 MHz
rst  in  1  synchronous, active-high reset
ce  in  1  pixel enable; counters advance only when high
pix_red  in  4  drawer red for current coordinates
pix_green  in  4  drawer green
pix_blue  in  4  drawer blue
VGA_HORZ_COORD  out  12  current horizontal count, 0..1687
VGA_VERT_COORD  out  12  current vertical count, 0..1065
VGA_ACTIVE  out  1  current coordinates inside 1280x1024
VGA_FRAME_START  out  1  one-cycle pulse at (0,0)
VGA_RED  out  4  registered red to connector
VGA_GREEN  out  4  registered green to connector
VGA_BLUE  out  4  registered blue to connector
VGA_HS  out  1  registered hsync, aligned to RGB
VGA_VS  out  1  registered vsync, aligned to RGB

Behaviour:
- Reset (rst=1 at clock edge): coords=0, VGA_ACTIVE=1, VGA_FRAME_START=1. RGB outputs=0. VGA_HS=VGA_VS=!SYNC_POL. The pipeline stage is cleared. Reset wins over ce.
- Horizontal counter: on ce, h <= (h==1687) ? 0 : h+1.
- Vertical counter: advances only when ce and h==1687. v <= (v==1065) ? 0 : v+1.
- Coordinates, VGA_ACTIVE and VGA_FRAME_START are derived directly from the counter registers, with no extra latency. VGA_ACTIVE = (h<H_ACTIVE)&&(v<V_ACTIVE). VGA_FRAME_START = (h==0)&&(v==0)&&ce.
- Horizontal phase FSM states: ACTIVE (h 0..1279), FRONT (1280..1327), SYNC (1328..1439), BACK (1440..1687).
- Vertical phase FSM states: ACTIVE (v 0..1023), FRONT (1024), SYNC (1025..1027), BACK (1028..1065).
- Each FSM transition occurs on the same edge the counter crosses the boundary. FSM state and counter must never disagree.
- Sync: hs_raw = SYNC_POL when H state is SYNC, else !SYNC_POL; vs_raw likewise from V state.
- Output pipeline, 1 stage: on ce, VGA_RED/GREEN/BLUE <= VGA_ACTIVE ? pix_* : 0, and VGA_HS <= hs_raw, VGA_VS <= vs_raw. Total latency from coordinate to pin is 1 enabled cycle, identical for colour and sync.
- ce=0: all registers hold, including the pipeline, and the FRAME_START pulse is suppressed.
- Widths: counters are 12-bit; max value 1687 < 4096, so there is no overflow. Boundary compares use exact equality to totals minus 1.
- Mid-frame reset restarts at (0,0) on the next edge; the first frame after reset is full length.

Optional Feature:
VGA_FRAME_CNT_EN.
- Defined: adds output VGA_FRAME_CNT [15:0]. Reset 0. Increments on each cycle where VGA_FRAME_START is high; wraps 65535 -> 0. Used by drawers for blink/animation.
- Undefined: the port and counter are absent; all other behaviour is unchanged.

Test Plan:
- Reset, then ce=1 for 1688 cycles -> h sweeps 0..1687, then wraps to 0. v goes 0 -> 1 exactly on the wrap edge.
- Run one full frame (1688*1066 = 1,799,408 cycles). Check VGA_FRAME_START pulses exactly once at (0,0); VGA_VS asserted (=1) for 3 lines; VGA_HS asserted 112 pixels per line.
- Drive pix_red=4'hA constantly. At h=1279,v=0 -> VGA_RED=A one cycle later. At h=1280 -> VGA_RED=0 one cycle later. Each VGA_HS edge lags its h boundary by exactly 1 cycle.
- Toggle ce 1/0 alternately -> counters advance every other clock. Outputs hold on ce=0. Frame period doubles to 3,598,816 clocks.
- Assert rst at h=700,v=500 -> next edge coords=(0,0), RGB=0, HS/VS=0. Normal counting resumes after rst drops.
- With VGA_FRAME_CNT_EN defined: run 3 frames -> VGA_FRAME_CNT = 3. Preload the counter via force to 65535 and cross one frame start -> 0.
